// File: rtl/ni_rx_depacketizer.sv
// Receive-side depacketizer: pairs head (address) and tail (data) flits into packets
// held in a show-ahead FIFO. Define NI_RX_ERR_CNT_EN to add a saturating err_count output.
module ni_rx_depacketizer #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int FLIT_W = 34
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] flit_in_data,
   input  logic              flit_in_valid,
   output logic              flit_in_ready,
   input  logic              core_read_en,
   output logic              core_read_valid,
   output logic [31:0]       core_read_addr,
   output logic [31:0]       core_read_data,
   output logic [PTR_W:0]    fifo_count,
   output logic              proto_err
`ifdef NI_RX_ERR_CNT_EN
   ,
   output logic [7:0]        err_count
`endif
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_TAIL = 1'b1
   } state_t;

   localparam logic [1:0]     TYPE_HEAD = 2'b01;
   localparam logic [1:0]     TYPE_TAIL = 2'b10;
   localparam logic [PTR_W:0] DEPTH_C   = DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] ONE_C     = {{PTR_W{1'b0}}, 1'b1};

   state_t             state_q;
   logic               ready_q;
   logic               proto_err_q;
   logic [31:0]        addr_hold_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [PTR_W:0]     count_q;
   logic [PTR_W:0]     count_d;
   logic [63:0]        mem [DEPTH];

   logic [1:0]         flit_type;
   logic [31:0]        payload;
   logic               accept;
   logic               is_head;
   logic               is_tail;
   logic               push;
   logic               pop;
   logic               err_evt;
   logic               next_idle;
   logic               not_empty;

   assign flit_type = flit_in_data[FLIT_W-1 -: 2];
   assign payload   = flit_in_data[31:0];
   assign accept    = flit_in_valid && ready_q;
   assign is_head   = (flit_type == TYPE_HEAD);
   assign is_tail   = (flit_type == TYPE_TAIL);
   assign not_empty = (count_q != '0);
   assign push      = accept && (state_q == WAIT_TAIL) && is_tail;
   assign pop       = core_read_en && not_empty;
   assign err_evt   = accept && (((state_q == IDLE) && !is_head) ||
                                 ((state_q == WAIT_TAIL) && !is_tail));
   assign next_idle = ((state_q == IDLE) && !(accept && is_head)) || push;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + ONE_C;
      end else if (!push && pop) begin
         count_d = count_q - ONE_C;
      end
   end

   // Ready is registered from next-cycle state and occupancy, so a pop while full
   // only raises it one cycle later and core_read_en never reaches it combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_hold_q <= '0;
         proto_err_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         if (accept) begin
            case (state_q)
               IDLE: begin
                  if (is_head) begin
                     addr_hold_q <= payload;
                     state_q     <= WAIT_TAIL;
                  end
               end
               WAIT_TAIL: begin
                  if (is_tail) begin
                     state_q <= IDLE;
                  end else if (is_head) begin
                     addr_hold_q <= payload;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
         if (err_evt) begin
            proto_err_q <= 1'b1;
         end
         ready_q <= next_idle || (count_d != DEPTH_C);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {addr_hold_q, payload};
      end
   end

   logic [63:0] head_entry;
   assign head_entry = mem[rd_ptr_q];

   assign flit_in_ready   = ready_q;
   assign core_read_valid = not_empty;
   assign core_read_addr  = not_empty ? head_entry[63:32] : 32'd0;
   assign core_read_data  = not_empty ? head_entry[31:0]  : 32'd0;
   assign fifo_count      = count_q;
   assign proto_err       = proto_err_q;

`ifdef NI_RX_ERR_CNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_count_q <= 8'd0;
      end else if (err_evt && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_ni_rx_depacketizer.sv
// Bench for ni_rx_depacketizer: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based packet model.
module tb_ni_rx_depacketizer;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [33:0] flit_in_data;
   logic        flit_in_valid;
   logic        flit_in_ready;
   logic        core_read_en;
   logic        core_read_valid;
   logic [31:0] core_read_addr;
   logic [31:0] core_read_data;
   logic [PTR_W:0] fifo_count;
   logic        proto_err;
`ifdef NI_RX_ERR_CNT_EN
   logic [7:0]  err_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ni_rx_depacketizer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .FLIT_W(34)) dut (
      .clk             (clk),
      .reset           (reset),
      .flit_in_data    (flit_in_data),
      .flit_in_valid   (flit_in_valid),
      .flit_in_ready   (flit_in_ready),
      .core_read_en    (core_read_en),
      .core_read_valid (core_read_valid),
      .core_read_addr  (core_read_addr),
      .core_read_data  (core_read_data),
      .fifo_count      (fifo_count),
      .proto_err       (proto_err)
`ifdef NI_RX_ERR_CNT_EN
      ,
      .err_count       (err_count)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: a packet is an address waiting for its data, then an entry in a queue.
   bit          m_init = 0;
   bit          m_have_addr;
   logic [31:0] m_addr;
   logic [63:0] m_q[$];
   bit          m_err;
   int          m_errcnt;
   bit          m_ready;

   always @(posedge clk) begin
      if (reset) begin
         m_init      = 1;
         m_have_addr = 0;
         m_addr      = '0;
         m_q.delete();
         m_err       = 0;
         m_errcnt    = 0;
         m_ready     = 1;
      end else if (m_init) begin
         bit acc, bad, do_pop;
         logic [1:0] t;
         t      = flit_in_data[33:32];
         acc    = flit_in_valid && m_ready;
         do_pop = core_read_en && (m_q.size() > 0);
         bad    = 0;
         if (do_pop) void'(m_q.pop_front());
         if (acc) begin
            if (!m_have_addr) begin
               if (t == 2'b01) begin
                  m_have_addr = 1;
                  m_addr      = flit_in_data[31:0];
               end else bad = 1;
            end else begin
               if (t == 2'b10) begin
                  m_q.push_back({m_addr, flit_in_data[31:0]});
                  m_have_addr = 0;
               end else begin
                  bad = 1;
                  if (t == 2'b01) m_addr = flit_in_data[31:0];
               end
            end
         end
         if (bad) begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
         end
         m_ready = !m_have_addr || (m_q.size() < DEPTH);
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("ready", 64'(flit_in_ready), 64'(m_ready));
         chk("read_valid", 64'(core_read_valid), 64'(m_q.size() != 0));
         chk("read_addr", 64'(core_read_addr), (m_q.size() != 0) ? 64'(m_q[0][63:32]) : 64'd0);
         chk("read_data", 64'(core_read_data), (m_q.size() != 0) ? 64'(m_q[0][31:0]) : 64'd0);
         chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
         chk("proto_err", 64'(proto_err), 64'(m_err));
`ifdef NI_RX_ERR_CNT_EN
         chk("err_count", 64'(err_count), 64'(m_errcnt));
`endif
      end
   end

   logic [63:0] popped[$];

   task automatic cyc();
      if (core_read_en && core_read_valid) popped.push_back({core_read_addr, core_read_data});
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [33:0] f);
      int n;
      flit_in_valid = 1'b1;
      flit_in_data  = f;
      n = 0;
      while (!flit_in_ready && n < 100) begin
         cyc();
         n++;
      end
      chk("send_timeout", 64'(n < 100), 64'd1);
      cyc();
      flit_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int maxc;
      reset = 1'b1;
      flit_in_valid = 1'b0;
      flit_in_data  = '0;
      core_read_en  = 1'b0;
      cyc();

      // Reset held with a valid head presented: nothing may be captured
      flit_in_valid = 1'b1;
      flit_in_data  = 34'h1_12345678;
      repeat (3) cyc();
      chk("rst_ready", 64'(flit_in_ready), 64'd1);
      chk("rst_valid", 64'(core_read_valid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_err", 64'(proto_err), 64'd0);
      chk("rst_addr", 64'(core_read_addr), 64'd0);
      reset = 1'b0;
      flit_in_valid = 1'b0;
      cyc();
      chk("rst_count2", 64'(fifo_count), 64'd0);

      // Basic packet
      send(34'h1_A5A5A5A5);
      send(34'h2_AAAAAAAA);
      chk("basic_valid", 64'(core_read_valid), 64'd1);
      chk("basic_addr", 64'(core_read_addr), 64'hA5A5A5A5);
      chk("basic_data", 64'(core_read_data), 64'hAAAAAAAA);
      chk("basic_count", 64'(fifo_count), 64'd1);
      core_read_en = 1'b1;
      cyc();
      core_read_en = 1'b0;
      chk("basic_valid_after", 64'(core_read_valid), 64'd0);
      chk("basic_count_after", 64'(fifo_count), 64'd0);

      // Fill and backpressure
      popped.delete();
      for (int i = 0; i < 4; i++) begin
         send({2'b01, 32'(i)});
         send({2'b10, 32'(32'h100 + i)});
      end
      send(34'h1_00000004);
      chk("fill_count", 64'(fifo_count), 64'd4);
      chk("fill_ready", 64'(flit_in_ready), 64'd0);
      flit_in_valid = 1'b1;
      flit_in_data  = 34'h2_00000104;
      cyc();
      chk("fill_ready_hold", 64'(flit_in_ready), 64'd0);
      core_read_en = 1'b1;
      cyc();
      core_read_en = 1'b0;
      chk("fill_ready_rise", 64'(flit_in_ready), 64'd1);
      chk("fill_count_pop", 64'(fifo_count), 64'd3);
      cyc();
      flit_in_valid = 1'b0;
      chk("fill_count_refill", 64'(fifo_count), 64'd4);
      core_read_en = 1'b1;
      repeat (4) cyc();
      core_read_en = 1'b0;
      chk("fill_drained", 64'(fifo_count), 64'd0);
      chk("fill_npop", 64'(popped.size()), 64'd5);
      for (int i = 0; i < 5 && i < popped.size(); i++)
         chk("fill_order", popped[i], {32'(i), 32'(32'h100 + i)});

      // Protocol errors
      do_reset();
      send(34'h2_DEADBEEF);
      chk("perr_flag", 64'(proto_err), 64'd1);
      chk("perr_count", 64'(fifo_count), 64'd0);
      send(34'h1_11111111);
      send(34'h1_22222222);
      send(34'h2_33333333);
      chk("perr_pkt_count", 64'(fifo_count), 64'd1);
      chk("perr_addr", 64'(core_read_addr), 64'h22222222);
      chk("perr_data", 64'(core_read_data), 64'h33333333);
`ifdef NI_RX_ERR_CNT_EN
      chk("perr_errcnt", 64'(err_count), 64'd2);
`endif
      core_read_en = 1'b1;
      cyc();
      // Empty read is ignored
      cyc();
      core_read_en = 1'b0;
      chk("empty_count", 64'(fifo_count), 64'd0);
      chk("empty_valid", 64'(core_read_valid), 64'd0);

      // Streaming with continuous pops, wrapping the pointers
      popped.delete();
      maxc = 0;
      core_read_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send({2'b01, 32'(32'h50 + i)});
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
         send({2'b10, 32'(32'hA00 + i)});
         if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      end
      cyc();
      core_read_en = 1'b0;
      chk("wrap_max_le1", 64'(maxc <= 1), 64'd1);
      chk("wrap_npop", 64'(popped.size()), 64'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         chk("wrap_order", popped[i], {32'(32'h50 + i), 32'(32'hA00 + i)});

      // Mid-packet reset
      send(34'h1_CAFE0000);
      do_reset();
      send(34'h2_0000BEEF);
      chk("midrst_err", 64'(proto_err), 64'd1);
      chk("midrst_count", 64'(fifo_count), 64'd0);

      // Random traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         flit_in_valid = ($urandom_range(0, 3) != 0);
         flit_in_data  = {(r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11, 32'($urandom)};
         core_read_en  = ($urandom_range(0, 2) == 0);
         reset         = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0;
      flit_in_valid = 1'b0;
      core_read_en = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
